// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 DW-bit mux: select, settle, capture, valid/ready out.
// Optional MUX8_SCHED_LOCK_EN adds a `lock` input that keeps the pointer on the accepted channel.
module mux8_rr_scheduler #(
  parameter int unsigned DW            = 8,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    req,
  input  logic [DW-1:0] mux_o,
  input  logic          out_ready,
`ifdef MUX8_SCHED_LOCK_EN
  input  logic          lock,
`endif
  output logic [2:0]    s,
  output logic [7:0]    grant,
  output logic [DW-1:0] out_data,
  output logic          out_valid
);

  localparam int unsigned NCH = 8;
  localparam int unsigned SW  = 3;
  localparam int unsigned CW  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_ptr;
  logic [SW-1:0]   r_s;
  logic [NCH-1:0]  r_grant;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_data;
  logic            r_valid;

  logic            w_found;
  logic [SW-1:0]   w_idx;
  logic [SW-1:0]   w_cand;
  logic [SW-1:0]   w_ptr_next;

  // First requesting channel at or after the pointer, wrapping mod 8.
  always_comb begin
    w_found = 1'b0;
    w_idx   = r_ptr;
    w_cand  = r_ptr;
    for (int unsigned k = 0; k < NCH; k++) begin
      w_cand = r_ptr + SW'(k);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  // r_s still holds the granted index while in HOLD.
`ifdef MUX8_SCHED_LOCK_EN
  assign w_ptr_next = lock ? r_s : r_s + SW'(1);
`else
  assign w_ptr_next = r_s + SW'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_s     <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_s     <= w_idx;
            r_grant <= NCH'(1) << w_idx;
            r_cnt   <= CW'(SETTLE_CYCLES - 1);
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_data  <= mux_o;
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_grant <= '0;
            r_ptr   <= w_ptr_next;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign s         = r_s;
  assign grant     = r_grant;
  assign out_data  = r_data;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Self-checking bench for mux8_rr_scheduler: directed scenarios plus random traffic
// checked every cycle against a transfer-level reference model.
module tb_mux8_rr_scheduler;

  localparam int SC = 1;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       out_ready;
  logic [7:0] mux_o;
  logic [2:0] s;
  logic [7:0] grant;
  logic [7:0] out_data;
  logic       out_valid;
`ifdef MUX8_SCHED_LOCK_EN
  logic       r_lock;
`endif

  logic [7:0] tbl [8] = '{8'hA0, 8'h51, 8'hA2, 8'h53, 8'hA4, 8'h55, 8'hA6, 8'h57};

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  mux8_rr_scheduler #(.DW(8), .SETTLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mux_o     (mux_o),
    .out_ready (out_ready),
`ifdef MUX8_SCHED_LOCK_EN
    .lock      (r_lock),
`endif
    .s         (s),
    .grant     (grant),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared mux: output follows the select.
  assign mux_o = tbl[s];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner = granted channel (-1 idle), age = edges since the grant.
  int         m_owner;
  int         m_age;
  int         m_ptr;
  int         m_s;
  logic [7:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_age   = 0;
      m_ptr   = 0;
      m_s     = 0;
      m_data  = 8'h00;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          m_s     = m_owner;
          m_age   = 0;
        end
      end
    end else if (m_age < SC) begin
      m_age = m_age + 1;
      if (m_age == SC) m_data = tbl[m_owner];
    end else if (out_ready) begin
`ifdef MUX8_SCHED_LOCK_EN
      m_ptr = r_lock ? m_owner : (m_owner + 1) % 8;
`else
      m_ptr = (m_owner + 1) % 8;
`endif
      m_owner = -1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_s",         32'(s),         32'(m_s));
      chk("model_grant",     32'(grant),     (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("model_out_valid", 32'(out_valid), (m_owner >= 0 && m_age >= SC) ? 32'd1 : 32'd0);
      chk("model_out_data",  32'(out_data),  32'(m_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer starting from IDLE, consumer always ready.
  task automatic xfer(input logic [7:0] rq, input int ch);
    req       = rq;
    out_ready = 1'b1;
    tick();
    chk("xfer_grant", 32'(grant), 32'd1 << ch);
    chk("xfer_s",     32'(s),     32'(ch));
    tick();
    chk("xfer_valid", 32'(out_valid), 32'd1);
    chk("xfer_data",  32'(out_data),  32'(tbl[ch]));
    tick();
    chk("xfer_idle_grant", 32'(grant),     32'd0);
    chk("xfer_idle_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 8'($urandom);
    out_ready = 1'($urandom);
`ifdef MUX8_SCHED_LOCK_EN
    r_lock    = 1'b0;
`endif
    tick();
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req       = 8'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    chk("rst_s",     32'(s),         32'd0);
    chk("rst_grant", 32'(grant),     32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);

    rst_n = 1'b1;
    req   = 8'h00;
    repeat (3) tick();
    chk("idle_grant", 32'(grant),     32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Single request; req dropped after the grant must not abort the transfer.
    req       = 8'h08;
    out_ready = 1'b1;
    tick();
    chk("single_s",     32'(s),     32'd3);
    chk("single_grant", 32'(grant), 32'h08);
    req = 8'h00;
    tick();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data",  32'(out_data),  32'h53);
    tick();
    chk("single_done", 32'(grant), 32'd0);
    xfer(8'h11, 4);

    // All requesting from ptr=0.
    pulse_reset();
    for (int n = 0; n < 9; n++) xfer(8'hFF, n % 8);

    // Backpressure.
    req       = 8'h10;
    out_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data",  32'(out_data),  32'hA4);
      chk("bp_s",     32'(s),         32'd4);
      chk("bp_grant", 32'(grant),     32'h10);
    end
    req       = 8'h00;
    out_ready = 1'b1;
    tick();
    chk("bp_accept", 32'(out_valid), 32'd0);

    // Wrap and fairness.
    xfer(8'h04, 2);
    xfer(8'h24, 5);
    xfer(8'h24, 2);
    xfer(8'h80, 7);
    xfer(8'h81, 0);

    // Reset while holding.
    xfer(8'h02, 1);
    req       = 8'h40;
    out_ready = 1'b0;
    tick();
    tick();
    chk("hold_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_s",     32'(s),         32'd0);
    chk("midrst_grant", 32'(grant),     32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data",  32'(out_data),  32'd0);
    tick();
    rst_n = 1'b1;
    xfer(8'h41, 0);

`ifdef MUX8_SCHED_LOCK_EN
    pulse_reset();
    r_lock = 1'b1;
    xfer(8'h06, 1);
    r_lock = 1'b0;
    xfer(8'h06, 1);
    xfer(8'h06, 2);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
      req       = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom) & 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
`ifdef MUX8_SCHED_LOCK_EN
      r_lock    = 1'($urandom);
`endif
      tick();
    end
    rst_n = 1'b1;
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux8_rr_scheduler.md
Name: mux8_rr_scheduler

Overview:
- Round-robin scheduler that shares one 8-to-1, DW-bit multiplexer between 8 requesters.
- Picks a requester, drives the mux select `s`, waits for the mux output to settle, then registers the selected word.
- Presents the word on a valid/ready output port.
- Sits between 8 data sources (mux inputs I0..I7) and a single downstream consumer.

Parameters:
- DW, 8, data width of the mux output and of `out_data`.
- SETTLE_CYCLES, 1, cycles `s` is held before `mux_o` is captured (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request per channel; bit i means channel i has data on mux input Ii.
- mux_o  input  DW  output of the shared multiplexer.
- s  output  3  select driven to the multiplexer.
- grant  output  8  one-hot current grant; 0 when idle.
- out_data  output  DW  captured word.
- out_valid  output  1  `out_data` valid.
- out_ready  input  1  consumer accepts `out_data`.

Behaviour:
- Reset: asynchronous on rst_n low, applies at any time including mid-transfer.
  - s=0, grant=0, out_data=0, out_valid=0.
  - Round-robin pointer ptr=0, settle counter=0, state IDLE.
  - Any transfer in flight is dropped.
- State IDLE:
  - If `req` is 0, stay in IDLE with grant=0; `s` keeps its last value.
  - Otherwise choose idx = first i with req[i]=1, searching ptr, ptr+1, ..., wrapping mod 8.
  - At that edge: s<=idx, grant<=1<<idx, counter<=SETTLE_CYCLES-1, go to SETTLE.
- State SETTLE:
  - `s` and `grant` are held stable.
  - While counter != 0, decrement it.
  - When counter == 0: out_data<=mux_o, out_valid<=1, go to HOLD.
- State HOLD:
  - out_valid=1; out_data, s and grant are held stable.
  - On an edge with out_ready=1: out_valid<=0, grant<=0, ptr<=(idx+1) mod 8 (3-bit wrap, 7 goes to 0), go to IDLE.
- Latency:
  - req sampled at edge k gives grant/s after edge k.
  - out_valid goes high after edge k+SETTLE_CYCLES.
  - Minimum period per transfer is SETTLE_CYCLES+2 cycles.
- Grant commitment: once granted, the transfer completes even if req[idx] drops during SETTLE or HOLD. Requests arriving during SETTLE/HOLD are considered only in the next IDLE.
- Simultaneous requests: resolved purely by ptr order. No channel waits more than 7 transfers.
- out_ready is ignored outside HOLD.
- Changes on mux_o outside the capture edge do not affect out_data.

Optional Feature:
- Macro: MUX8_SCHED_LOCK_EN.
- Defined:
  - Adds input port `lock` (1 bit).
  - If lock=1 on the accepting edge in HOLD, ptr is set to idx instead of idx+1.
  - The same channel therefore wins the next IDLE arbitration if its req is still high. If its req is low, normal search proceeds from idx.
- Undefined: no `lock` port; ptr always advances to idx+1.

Test Plan:
- Bench setup: the mux is modelled with I0..I7 = A0,51,A2,53,A4,55,A6,57 and SETTLE_CYCLES=1.
- Reset: hold rst_n=0 with random req/out_ready -> s=0, grant=00, out_valid=0, out_data=00. Release rst_n, drive req=00 -> remains idle.
- Single request: req=08, out_ready=1 -> after edge 1: s=3, grant=08; after edge 2: out_valid=1, out_data=53. After acceptance grant=00 and ptr=4.
- All requesting: req=FF, out_ready=1 -> grant sequence 01,02,04,...,80,01. out_data sequence A0,51,A2,53,A4,55,A6,57,A0, one word every 3 cycles.
- Backpressure: req=10, out_ready=0 for 5 cycles -> out_valid=1, out_data=A4, s=4, grant=10 all stable. Set out_ready=1 -> accepted once, out_valid=0 next cycle.
- Wrap and fairness: after grant to channel 2, set req=24 -> grant 20 (out 55), then 04 (out A2). After grant 80, req=81 -> next grant is 01.
- Reset mid-HOLD: req=40, out_ready=0, pulse rst_n low in HOLD -> outputs cleared immediately. With req=41 after release, the first grant is 01 (ptr=0).
- With MUX8_SCHED_LOCK_EN: req=06, lock=1 on accept of channel 1 -> next grant is 02 again. With lock=0 -> next grant is 04.
